// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer that owns the HI/LO registers.
// Optional MULDIV_EARLY_TERM_EN: multiplies finish once the multiplier runs out.
module muldiv_sequencer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] rs_data,
    input  logic [DATA_WIDTH-1:0] rt_data,
    input  logic                  abort,
    input  logic                  hi_we,
    input  logic                  lo_we,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  div_zero,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CALC  = 2'd1;
    localparam logic [1:0] S_FIXUP = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] count;
    logic          is_div;
    logic          neg_res;
    logic          neg_rem;
    logic          dz;

    // Divide reuses acc as {remainder, quotient} and mplier as the divisor.
    logic [2*W-1:0] acc;
    logic [2*W-1:0] mcand;
    logic [W-1:0]   mplier;

    logic           rs_neg;
    logic           rt_neg;
    logic [W-1:0]   mag_rs;
    logic [W-1:0]   mag_rt;
    logic [W-1:0]   rem;
    logic [W-1:0]   quo;
    logic [W:0]     shifted;
    logic [W:0]     trial;
    logic [2*W-1:0] acc_sum;
    logic [2*W-1:0] prod;
    logic [W-1:0]   quo_s;
    logic [W-1:0]   rem_s;
    logic           last_iter;

    assign rs_neg  = op[0] & rs_data[W-1];
    assign rt_neg  = op[0] & rt_data[W-1];
    assign mag_rs  = rs_neg ? -rs_data : rs_data;
    assign mag_rt  = rt_neg ? -rt_data : rt_data;

    assign rem     = acc[2*W-1:W];
    assign quo     = acc[W-1:0];
    assign shifted = {rem, quo[W-1]};
    assign trial   = shifted - {1'b0, mplier};
    assign acc_sum = acc + mcand;

    // With a zero divisor the remainder ends as |rs|, so re-signing it gives rs.
    assign prod    = neg_res ? -acc : acc;
    assign quo_s   = neg_res ? -quo : quo;
    assign rem_s   = neg_rem ? -rem : rem;

`ifdef MULDIV_EARLY_TERM_EN
    assign last_iter = (count == LAST) || (!is_div && (mplier == '0));
`else
    assign last_iter = (count == LAST);
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            count    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            dz       <= 1'b0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        state   <= S_CALC;
                        busy    <= 1'b1;
                        count   <= '0;
                        is_div  <= op[1];
                        neg_res <= rs_neg ^ rt_neg;
                        neg_rem <= rs_neg;
                        dz      <= op[1] && (rt_data == '0);
                        mplier  <= mag_rt;
                        if (op[1]) begin
                            acc   <= {{W{1'b0}}, mag_rs};
                            mcand <= '0;
                        end else begin
                            acc   <= '0;
                            mcand <= {{W{1'b0}}, mag_rs};
                        end
                    end else begin
                        if (hi_we) hi <= wr_data;
                        if (lo_we) lo <= wr_data;
                    end
                end
                S_CALC: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        count <= count + 1'b1;
                        if (last_iter) state <= S_FIXUP;
                        if (is_div) begin
                            if (trial[W])
                                acc <= {shifted[W-1:0], quo[W-2:0], 1'b0};
                            else
                                acc <= {trial[W-1:0], quo[W-2:0], 1'b1};
                        end else begin
                            if (mplier[0]) acc <= acc_sum;
                            mcand  <= {mcand[2*W-2:0], 1'b0};
                            mplier <= {1'b0, mplier[W-1:1]};
                        end
                    end
                end
                S_FIXUP: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    if (!abort) begin
                        done     <= 1'b1;
                        div_zero <= dz;
                        if (is_div) begin
                            hi <= rem_s;
                            lo <= dz ? '1 : quo_s;
                        end else begin
                            hi <= prod[2*W-1:W];
                            lo <= prod[W-1:0];
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomised bench for muldiv_sequencer against an arithmetic reference model.
// Follows MULDIV_EARLY_TERM_EN for expected multiply latency.
module tb_muldiv_sequencer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        abort = 1'b0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wr_data = '0;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    muldiv_sequencer #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data), .abort(abort),
        .hi_we(hi_we), .lo_we(lo_we), .wr_data(wr_data),
        .busy(busy), .done(done), .div_zero(div_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] act,
                                logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endfunction

    // {div_zero, hi, lo} from plain arithmetic
    function automatic logic [64:0] model_res(logic [1:0] o,
                                              logic [31:0] a,
                                              logic [31:0] b);
        longint sa, sb;
        logic [63:0] p;
        logic [64:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (o == 2'd0) begin
            p = {32'b0, a} * {32'b0, b};
            r = {1'b0, p};
        end else if (o == 2'd1) begin
            p = 64'(sa * sb);
            r = {1'b0, p};
        end else if (b == 32'd0) begin
            r = {1'b1, a, 32'hFFFF_FFFF};
        end else if (o == 2'd2) begin
            r = {1'b0, a % b, a / b};
        end else begin
            r = {1'b0, 32'(sa % sb), 32'(sa / sb)};
        end
        return r;
    endfunction

    // edges from the accepting edge to the edge that raises done
    function automatic int exp_lat(logic [1:0] o, logic [31:0] b);
        int n;
        logic [31:0] m;
        n = 0;
        m = (o[0] && b[31]) ? -b : b;
        for (int i = 0; i < 32; i++)
            if (m[i]) n = i + 1;
`ifdef MULDIV_EARLY_TERM_EN
        if (!o[1]) return (n + 1 >= 32) ? 33 : n + 2;
`endif
        return 33 + 0 * n;
    endfunction

    bit          m_ok = 0;
    bit          m_pend = 0;
    bit          m_done = 0;
    bit          m_dz = 0;
    int          m_cnt = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [64:0] m_res = '0;

    always @(posedge clk) begin
        m_done = 0;
        m_dz   = 0;
        if (!reset_n) begin
            m_pend = 0;
            m_hi   = '0;
            m_lo   = '0;
            m_ok   = 1;
        end else if (m_pend) begin
            if (abort) begin
                m_pend = 0;
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_pend = 0;
                    m_done = 1;
                    {m_dz, m_hi, m_lo} = m_res;
                end
            end
        end else if (start && !abort) begin
            m_pend = 1;
            m_cnt  = exp_lat(op, rt_data);
            m_res  = model_res(op, rs_data, rt_data);
        end else begin
            if (hi_we) m_hi = wr_data;
            if (lo_we) m_lo = wr_data;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("busy", 64'(busy), 64'(m_pend));
            chk("done", 64'(done), 64'(m_done));
            chk("div_zero", 64'(div_zero), 64'(m_dz));
            chk("hi", 64'(hi), 64'(m_hi));
            chk("lo", 64'(lo), 64'(m_lo));
        end
    end

    task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int abort_at,
                          output int lat);
        start = 1'b1;
        op = o;
        rs_data = a;
        rt_data = b;
        @(posedge clk); #1;
        start = 1'b0;
        rs_data = $urandom;
        rt_data = $urandom;
        op = 2'($urandom);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            if (i == abort_at) abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            if (done || !busy) begin
                lat = i;
                break;
            end
        end
        chk("op_completes", 64'(lat > 0), 64'd1);
    endtask

    task automatic idle(input int n, input bit wr);
        for (int i = 0; i < n; i++) begin
            hi_we = wr & 1'($urandom);
            lo_we = wr & 1'($urandom);
            wr_data = $urandom;
            @(posedge clk); #1;
        end
        hi_we = 1'b0;
        lo_we = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    int lat;
    logic [64:0] pin;

    initial begin
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);

        pin = model_res(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("pin_multu", pin[63:0], 64'hFFFF_FFFE_0000_0001);
        pin = model_res(2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("pin_div_ovf", pin[63:0], 64'h0000_0000_8000_0000);
        pin = model_res(2'd3, 32'hFFFF_FFF9, 32'd2);
        chk("pin_div_neg", pin[63:0], 64'hFFFF_FFFF_FFFF_FFFD);

        run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat);
        chk("t1_hi", 64'(hi), 64'hFFFF_FFFE);
        chk("t1_lo", 64'(lo), 64'h0000_0001);
        chk("t1_lat", 64'(lat), 64'd33);

        // back-to-back: each op starts in the previous done cycle
        run_op(2'd1, 32'hFFFF_FFFD, 32'd7, 0, lat);
        chk("t2_mult_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("t2_mult_lo", 64'(lo), 64'hFFFF_FFEB);
        run_op(2'd3, 32'hFFFF_FFF9, 32'd2, 0, lat);
        chk("t2_div_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("t2_div_lo", 64'(lo), 64'hFFFF_FFFD);
        chk("t2_div_lat", 64'(lat), 64'd33);

        run_op(2'd2, 32'd100, 32'd0, 0, lat);
        chk("t3_dz_flag", 64'(div_zero), 64'd1);
        chk("t3_dz_hi", 64'(hi), 64'd100);
        chk("t3_dz_lo", 64'(lo), 64'hFFFF_FFFF);
        chk("t3_dz_lat", 64'(lat), 64'd33);
        run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat);
        chk("t3_ovf_hi", 64'(hi), 64'd0);
        chk("t3_ovf_lo", 64'(lo), 64'h8000_0000);

        idle(2, 0);
        run_op(2'd2, 32'd1000, 32'd7, 10, lat);
        chk("t4_abort_lat", 64'(lat), 64'd10);
        chk("t4_abort_busy", 64'(busy), 64'd0);
        chk("t4_abort_hi", 64'(hi), 64'd0);
        chk("t4_abort_lo", 64'(lo), 64'h8000_0000);
        idle(3, 0);

        start = 1'b1; op = 2'd2; rs_data = 32'd50; rt_data = 32'd5;
        @(posedge clk); #1;
        op = 2'd0; rs_data = 32'd3; rt_data = 32'd3;
        hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'h1234;
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk); #1;
        end
        chk("t5_busy_hi", 64'(hi), 64'd0);
        chk("t5_busy_lo", 64'(lo), 64'd10);
        @(posedge clk); #1;
        hi_we = 1'b1; wr_data = 32'h1234;
        @(posedge clk); #1;
        hi_we = 1'b0;
        chk("t5_mthi", 64'(hi), 64'h1234);

        hi_we = 1'b1; wr_data = 32'hDEAD;
        run_op(2'd0, 32'd2, 32'd3, 0, lat);
        hi_we = 1'b0;
        chk("t5_start_wins_hi", 64'(hi), 64'd0);
        chk("t5_start_wins_lo", 64'(lo), 64'd6);

        start = 1'b1; abort = 1'b1; op = 2'd0;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("abort_start_busy", 64'(busy), 64'd0);

        run_op(2'd0, 32'd5, 32'd0, 0, lat);
`ifdef MULDIV_EARLY_TERM_EN
        chk("t6_rt0_lat", 64'(lat), 64'd2);
`else
        chk("t6_rt0_lat", 64'(lat), 64'd33);
`endif
        chk("t6_rt0_hi", 64'(hi), 64'd0);
        chk("t6_rt0_lo", 64'(lo), 64'd0);
        run_op(2'd1, 32'd9, 32'd1, 0, lat);
`ifdef MULDIV_EARLY_TERM_EN
        chk("t6_rt1_lat", 64'(lat), 64'd3);
`else
        chk("t6_rt1_lat", 64'(lat), 64'd33);
`endif
        chk("t6_rt1_lo", 64'(lo), 64'd9);

        idle(1, 1);
        start = 1'b1; op = 2'd3; rs_data = 32'd77; rt_data = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_hi", 64'(hi), 64'd0);
        chk("midrst_lo", 64'(lo), 64'd0);
        idle(2, 0);

        for (int n = 0; n < 300; n++) begin
            int ab;
            ab = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 35) : 0;
            run_op(2'($urandom), pick(), pick(), ab, lat);
            if (busy) begin
                repeat (2) @(posedge clk);
                #1;
            end
            idle($urandom_range(0, 2), 1);
        end

        idle(3, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
